// File: rtl/mem_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states, requester IDs, default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LD  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on en, sticks at all-ones, cleared by async active-low reset.
// Count is registered (visible the cycle after en); no backpressure.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between the CPU and the loader (ARB_RR_EN: round-robin on conflict).
// Latency: request sampled in IDLE at T, ack at T+2; next access starts no sooner than T+3.
// Backpressure: requests are held until ack and only sampled in IDLE; losers simply wait.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              grant,
  output logic [CNT_W-1:0]  conflict_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic              start;
  logic              winner;
  logic              both_req;
  logic              conflict_en;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ld_rdata_q;

  assign both_req    = cpu_req & ld_req;
  assign conflict_en = (state == ST_IDLE) & both_req;

`ifdef ARB_RR_EN
  logic last_q;

  // Starts at loader so the very first conflict goes to the CPU.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q <= GNT_LD;
    end else if (start) begin
      last_q <= winner;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
`ifdef ARB_RR_EN
    winner    = both_req ? ~last_q : (cpu_req ? GNT_CPU : GNT_LD);
`else
    winner    = cpu_req ? GNT_CPU : GNT_LD;
`endif
    case (state)
      ST_IDLE: begin
        if (cpu_req || ld_req) begin
          start     = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      grant_q     <= GNT_CPU;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      if (start) begin
        grant_q <= winner;
        we_q    <= (winner == GNT_LD) ? ld_we    : cpu_we;
        addr_q  <= (winner == GNT_LD) ? ld_addr  : cpu_addr;
        wdata_q <= (winner == GNT_LD) ? ld_wdata : cpu_wdata;
      end
      // Keep the read value after the ack so rdata holds between transactions.
      if ((state == ST_RESP) && !we_q) begin
        if (grant_q == GNT_LD) begin
          ld_rdata_q <= mem_q;
        end else begin
          cpu_rdata_q <= mem_q;
        end
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_conflict_cnt (
    .clock (clock),
    .reset (reset),
    .en    (conflict_en),
    .count (conflict_cnt)
  );

  // Strobes decode from state alone so reset kills an in-flight write at once.
  assign mem_rden    = (state == ST_ACCESS) & ~we_q;
  assign mem_wren    = (state == ST_ACCESS) &  we_q;
  assign mem_address = addr_q;
  assign mem_data    = wdata_q;

  assign cpu_ack   = (state == ST_RESP) & (grant_q == GNT_CPU);
  assign ld_ack    = (state == ST_RESP) & (grant_q == GNT_LD);
  assign cpu_rdata = (cpu_ack && !we_q) ? mem_q : cpu_rdata_q;
  assign ld_rdata  = (ld_ack  && !we_q) ? mem_q : ld_rdata_q;

  assign busy  = (state != ST_IDLE);
  assign grant = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of transactions plus conflict, saturation and reset sequences.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CW = 8;

  logic          clock;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ld_req, ld_we, ld_ack;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata, ld_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, mem_q;
  logic          mem_rden, mem_wren;
  logic          busy, grant;
  logic [CW-1:0] conflict_cnt;

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .ld_req       (ld_req),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_wdata     (ld_wdata),
    .ld_ack       (ld_ack),
    .ld_rdata     (ld_rdata),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_rden     (mem_rden),
    .mem_wren     (mem_wren),
    .mem_q        (mem_q),
    .busy         (busy),
    .grant        (grant),
    .conflict_cnt (conflict_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory with registered read data.
  logic [DW-1:0] mem [256];
  always @(posedge clock) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  typedef struct {
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wd;
    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wd;
    logic          first;     // expected first winner (0 cpu, 1 loader)
    logic          two;       // both requesters served
    logic [DW-1:0] rd_first;
    logic [DW-1:0] rd_second;
    logic [CW-1:0] exp_cnt;
    logic          exp_grant;
  } vec_t;

  vec_t vecs [9];

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_cpu_rd = '0;
  logic [DW-1:0] exp_ld_rd  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output logic who, output int cyc, output logic ok);
    who = 1'b0;
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      cyc++;
      if (cpu_ack || ld_ack) begin
        who = ld_ack;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic update_rd(input logic who, input logic we, input logic [DW-1:0] rd);
    if (!we) begin
      if (who) exp_ld_rd = rd;
      else     exp_cpu_rd = rd;
    end
  endtask

  // Called at a falling edge while the DUT is in IDLE; returns at a falling edge in IDLE.
  task automatic run_vec(input vec_t v, input string tag);
    logic who, ok, fwe, swe;
    int   cyc;
    fwe = v.first ? v.l_we : v.c_we;
    swe = v.first ? v.c_we : v.l_we;
    cpu_req = v.c_req; cpu_we = v.c_we; cpu_addr = v.c_addr; cpu_wdata = v.c_wd;
    ld_req  = v.l_req; ld_we  = v.l_we; ld_addr  = v.l_addr; ld_wdata  = v.l_wd;
    @(negedge clock);
    chk({tag, ".access_wren"}, 64'(mem_wren), 64'(fwe));
    chk({tag, ".access_rden"}, 64'(mem_rden), 64'(!fwe));
    wait_ack(who, cyc, ok);
    chk({tag, ".ack_seen"}, 64'(ok), 64'd1);
    chk({tag, ".ack_latency"}, 64'(cyc), 64'd1);
    chk({tag, ".winner"}, 64'(who), 64'(v.first));
    chk({tag, ".ack_onehot"}, 64'(cpu_ack & ld_ack), 64'd0);
    chk({tag, ".strobes_in_resp"}, 64'({mem_rden, mem_wren}), 64'd0);
    update_rd(v.first, fwe, v.rd_first);
    chk({tag, ".cpu_rdata"}, 64'(cpu_rdata), 64'(exp_cpu_rd));
    chk({tag, ".ld_rdata"}, 64'(ld_rdata), 64'(exp_ld_rd));
    if (v.first) ld_req = 1'b0;
    else         cpu_req = 1'b0;
    if (v.two) begin
      wait_ack(who, cyc, ok);
      chk({tag, ".ack2_seen"}, 64'(ok), 64'd1);
      chk({tag, ".ack2_gap"}, 64'(cyc), 64'd3);
      chk({tag, ".winner2"}, 64'(who), 64'(!v.first));
      update_rd(!v.first, swe, v.rd_second);
      chk({tag, ".cpu_rdata2"}, 64'(cpu_rdata), 64'(exp_cpu_rd));
      chk({tag, ".ld_rdata2"}, 64'(ld_rdata), 64'(exp_ld_rd));
    end
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    @(negedge clock);
    chk({tag, ".ack_pulse_end"}, 64'({cpu_ack, ld_ack, busy}), 64'd0);
    chk({tag, ".conflict_cnt"}, 64'(conflict_cnt), 64'(v.exp_cnt));
    chk({tag, ".grant"}, 64'(grant), 64'(v.exp_grant));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic who, ok, exp_w;
    int   cyc;

    //             c_req c_we  c_addr c_wd    l_req l_we  l_addr l_wd    first two   rd1    rd2    cnt    grant
    vecs[0] = '{1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 8'h30, 8'h5A, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'h00, 8'hA5, 8'h01, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 8'h40, 8'h77, 1'b0, 1'b1, 8'h5A, 8'h00, 8'h02, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h77, 8'h00, 8'hFF, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'h50, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h11, 8'h00, 8'h00, 1'b0};

    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req  = 1'b0; ld_we  = 1'b0; ld_addr  = '0; ld_wdata  = '0;
    repeat (3) @(negedge clock);
    chk("reset.outputs_zero",
        64'({cpu_ack, ld_ack, busy, grant, mem_rden, mem_wren, cpu_rdata, ld_rdata,
             mem_address, mem_data, conflict_cnt}), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held high: every IDLE cycle is a conflict.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 8'h20;
    for (int k = 0; k < 300; k++) begin
      wait_ack(who, cyc, ok);
      if (!ok) begin
        chk("hold.ack_seen", 64'(ok), 64'd1);
        break;
      end
      if (who) exp_ld_rd = 8'h3C;
      else     exp_cpu_rd = 8'hA5;
      if (k < 3) begin
`ifdef ARB_RR_EN
        exp_w = (k % 2 == 1);
`else
        exp_w = 1'b0;
`endif
        chk($sformatf("hold.winner%0d", k), 64'(who), 64'(exp_w));
        chk($sformatf("hold.rdata%0d", k), 64'(who ? ld_rdata : cpu_rdata),
            64'(who ? exp_ld_rd : exp_cpu_rd));
      end
      if (k == 2)   chk("hold.cnt_after3", 64'(conflict_cnt), 64'd5);
      if (k == 251) chk("hold.cnt_254", 64'(conflict_cnt), 64'hFE);
      if (k == 252) chk("hold.cnt_255", 64'(conflict_cnt), 64'hFF);
    end
    chk("hold.cnt_saturated", 64'(conflict_cnt), 64'hFF);
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    @(negedge clock);

    run_vec(vecs[6], "vec6");

    // Reset during the ACCESS cycle of a write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'h11;
    @(negedge clock);
    chk("rst.wren_before", 64'(mem_wren), 64'd1);
    reset = 1'b0;
    #1;
    chk("rst.wren_dropped", 64'(mem_wren), 64'd0);
    chk("rst.outputs_zero",
        64'({cpu_ack, ld_ack, busy, grant, mem_rden, mem_wren, cpu_rdata, ld_rdata,
             mem_address, mem_data, conflict_cnt}), 64'd0);
    cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk($sformatf("rst.no_ack%0d", i), 64'({cpu_ack, ld_ack}), 64'd0);
    end
    reset = 1'b1;
    exp_cpu_rd = '0;
    exp_ld_rd  = '0;
    run_vec(vecs[7], "vec7");
    run_vec(vecs[8], "vec8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port (address/data/q, rden/wren) between two requesters:
  - the processor data path;
  - a program/data loader used to preload memory from switches or a debug host.
- Sits between the control FSM's MemRead/MemWrite path and the data port of the memory block.
- Sequences each access as a fixed three-state transaction with a req/ack handshake.
- Exposes busy, grant and conflict status for LED/HEX debug display.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
CNT_W, 8, width of saturating conflict counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  processor access request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
cpu_addr  in  ADDR_W  processor address
cpu_wdata  in  DATA_W  processor write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid while cpu_ack high
ld_req  in  1  loader request; held until ld_ack
ld_we  in  1  loader write enable
ld_addr  in  ADDR_W  loader address
ld_wdata  in  DATA_W  loader write data
ld_ack  out  1  one-cycle completion pulse
ld_rdata  out  DATA_W  read data, valid while ld_ack high
mem_address  out  ADDR_W  to memory data port
mem_data  out  DATA_W  to memory write data
mem_rden  out  1  memory read enable
mem_wren  out  1  memory write enable
mem_q  in  DATA_W  memory registered read data (valid one cycle after address)
busy  out  1  high in ACCESS and RESP states
grant  out  1  0 = cpu, 1 = loader; holds the last winner
conflict_cnt  out  CNT_W  saturating count of simultaneous requests

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE; all outputs 0; conflict_cnt 0; grant 0.
  - mem_wren/mem_rden decode from state, so an in-flight write is aborted immediately.
- Three states:
  - IDLE: samples cpu_req/ld_req. If any is high, latch the winner's we/addr/wdata into internal registers, set grant, go to ACCESS. Otherwise stay.
  - ACCESS: drive mem_address/mem_data from the latched values. mem_wren = latched we; mem_rden = ~latched we. Always go to RESP.
  - RESP: pulse the winner's ack. Winner's rdata = mem_q for a read, unchanged for a write. mem_rden/mem_wren low. Always go to IDLE.
- Latency:
  - request seen in IDLE at cycle T → ack at T+2.
  - back-to-back accesses start no sooner than T+3.
- Requests are sampled only in IDLE.
  - A requester must drop req in the cycle after ack, or it is treated as a new transaction.
  - Changing req inputs mid-transaction has no effect (inputs are latched).
- Fixed priority (default): CPU wins when both requests are high in IDLE.
- Conflict: both req high in IDLE → conflict_cnt increments; it saturates at 2^CNT_W−1 and does not wrap.
- Non-winner rdata registers hold their previous values.
- mem_address/mem_data hold the latched values outside ACCESS; no combinational path from req inputs to memory.
- Reset asserted in ACCESS or RESP: no ack is issued. Requesters must re-request after reset.

Optional Feature:
ARB_RR_EN
- Defined: round-robin on conflict. The requester not granted on the previous transaction wins. The last-winner register resets to loader, so the first conflict goes to the CPU. Uncontested requests are unaffected.
- Undefined: fixed CPU priority as above. The last-winner register is not synthesized.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding constants ST_IDLE, ST_ACCESS, ST_RESP;
  - requester IDs GNT_CPU = 0, GNT_LD = 1;
  - default widths.
- One sub-module, sat_counter (width parameter, enable, async active-low clear, saturates at max), used for conflict_cnt.
- FSM, winner select and data registers stay in the top module.

Test Plan:
- CPU write addr 0x10 data 0xA5, then CPU read 0x10 → mem_wren high exactly in ACCESS; read cpu_ack at T+2 with cpu_rdata = 0xA5; ld_ack stays 0.
- Loader writes 0x3C to 0x20 while cpu_req is low → grant = 1; ld_ack at T+2; conflict_cnt stays 0.
- Both req high in the same IDLE cycle, fixed priority → CPU served first, loader acked 3 cycles later; conflict_cnt = 1.
- With ARB_RR_EN, three consecutive conflicts → grant sequence cpu, ld, cpu (counting winners of the conflict cycles); conflict_cnt = 3.
- Hold both req high for 300 conflicts with CNT_W = 8 → conflict_cnt saturates at 0xFF.
- Assert reset low during ACCESS of a write → mem_wren drops in the same cycle; no ack; all outputs 0; after release, a re-issued request completes normally.
